// File: rtl/uart_probe_pkg.sv
// Shared definitions for the UART-driven AXI4-Lite probe: opcodes, FSM states,
// ctrl-byte bit positions and byte-lane helpers.
package uart_probe_pkg;

    localparam logic [7:0] OP_GPI_RD0  = 8'h02;
    localparam logic [7:0] OP_GPI_RD3  = 8'h05;
    localparam logic [7:0] OP_GPO_RD0  = 8'h06;
    localparam logic [7:0] OP_GPO_RD3  = 8'h09;
    localparam logic [7:0] OP_GPO_WR0  = 8'h0A;
    localparam logic [7:0] OP_GPO_WR3  = 8'h0D;
    localparam logic [7:0] OP_ADDR_RD0 = 8'h0E;
    localparam logic [7:0] OP_ADDR_RD3 = 8'h11;
    localparam logic [7:0] OP_ADDR_WR0 = 8'h12;
    localparam logic [7:0] OP_ADDR_WR3 = 8'h15;
    localparam logic [7:0] OP_DATA_RD  = 8'h16;
    localparam logic [7:0] OP_AXI_WR   = 8'h17;
    localparam logic [7:0] OP_CTRL_RD  = 8'h18;
    localparam logic [7:0] OP_CTRL_WR  = 8'h19;

    // Ctrl read-byte layout and ctrl write-operand bits.
    localparam int CTRL_BUSY    = 0;
    localparam int CTRL_BRESP   = 2;
    localparam int CTRL_RRESP   = 4;
    localparam int CTRL_WR_READ = 0;
    localparam int CTRL_WR_INC  = 1;

    localparam logic [2:0] AXI_SIZE_32 = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG,
        ST_RESP,
        ST_AXI_RD,
        ST_AXI_WR
    } state_t;

    // Every byte-addressed opcode group starts on a value = 2 mod 4.
    function automatic logic [1:0] byte_idx(input logic [7:0] op);
        return op[1:0] - 2'd2;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] set_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic is_read_op(input logic [7:0] op);
        return (op inside {[OP_GPI_RD0:OP_GPO_RD3], [OP_ADDR_RD0:OP_ADDR_RD3],
                           OP_DATA_RD, OP_CTRL_RD});
    endfunction

    function automatic logic is_write_op(input logic [7:0] op);
        return (op inside {[OP_GPO_WR0:OP_GPO_WR3], [OP_ADDR_WR0:OP_ADDR_WR3],
                           OP_AXI_WR, OP_CTRL_WR});
    endfunction

endpackage

// File: rtl/uart_probe_axi_master.sv
// Single-beat AXI4-Lite master: AR/R read sequencing and AW/W/B write sequencing,
// launched by one-cycle start strobes from the command FSM.
module uart_probe_axi_master
    import uart_probe_pkg::*;
(
    input  logic        clk,
    input  logic        m_areset,
    input  logic        start_rd,
    input  logic        start_wr,
    input  logic [31:0] rd_addr,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        rd_done,
    output logic        wr_done,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arsize,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awsize,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    logic wr_busy;
    logic aw_last;
    logic w_last;
    logic resp_unused;

    assign m_axi_arsize = AXI_SIZE_32;
    assign m_axi_awsize = AXI_SIZE_32;
    assign m_axi_wstrb  = 4'b1111;

    assign rd_done = m_axi_rready & m_axi_rvalid;
    assign wr_done = m_axi_bready & m_axi_bvalid;

    // An address/data channel is finished once it is idle or handshaking this edge.
    assign aw_last = !m_axi_awvalid || m_axi_awready;
    assign w_last  = !m_axi_wvalid  || m_axi_wready;

    // Response payloads are captured by the command block; only the handshakes matter here.
    assign resp_unused = ^{m_axi_rdata, m_axi_rresp, m_axi_bresp};

    always_ff @(posedge clk) begin
        if (m_areset) begin
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            wr_busy       <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignments so every branch sees pre-edge values.
            if (start_rd) begin
                m_axi_araddr  <= rd_addr;
                m_axi_arvalid <= 1'b1;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b1;
            end
            if (rd_done) m_axi_rready <= 1'b0;

            if (start_wr) begin
                m_axi_awaddr  <= wr_addr;
                m_axi_wdata   <= wr_data;
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
                wr_busy       <= 1'b1;
            end
            if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
            if (wr_busy && !m_axi_bready && aw_last && w_last) m_axi_bready <= 1'b1;
            if (wr_done) begin
                m_axi_bready <= 1'b0;
                wr_busy      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_probe.sv
// Byte-command probe: decodes a UART-style command stream into GPIO and
// AXI4-Lite register accesses and answers read commands with one byte.
module uart_probe
    import uart_probe_pkg::*;
(
    input  logic        clk,
    input  logic        m_areset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] gpo,
    input  logic [31:0] gpi,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arsize,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awsize,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    state_t      state, state_n;
    logic [7:0]  op_q;
    logic [31:0] addr_q, addr_n;
    logic [31:0] gpo_n;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q, bresp_q;
    logic [7:0]  resp_byte;
    logic [7:0]  ctrl_byte;
    logic        rx_accept, tx_done;
    logic        load_tx, start_rd, start_wr;
    logic        rd_done, wr_done;
    logic        rdata_unused;

    assign rx_accept = rx_valid & rx_ready;
    assign tx_done   = tx_valid & tx_ready;

    // Only the low byte of the read data is visible over the command stream.
    assign rdata_unused = ^rdata_q[31:8];

    always_comb begin
        ctrl_byte                      = 8'h00;
        ctrl_byte[CTRL_BUSY]           = (state == ST_AXI_RD) || (state == ST_AXI_WR);
        ctrl_byte[CTRL_BRESP +: 2]     = bresp_q;
        ctrl_byte[CTRL_RRESP +: 2]     = rresp_q;

        resp_byte = 8'h00;
        if (rx_data inside {[OP_GPI_RD0:OP_GPI_RD3]})
            resp_byte = get_byte(gpi, byte_idx(rx_data));
        else if (rx_data inside {[OP_GPO_RD0:OP_GPO_RD3]})
            resp_byte = get_byte(gpo, byte_idx(rx_data));
        else if (rx_data inside {[OP_ADDR_RD0:OP_ADDR_RD3]})
            resp_byte = get_byte(addr_q, byte_idx(rx_data));
        else if (rx_data == OP_DATA_RD)
            resp_byte = rdata_q[7:0];
        else if (rx_data == OP_CTRL_RD)
            resp_byte = ctrl_byte;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n  = state;
        gpo_n    = gpo;
        addr_n   = addr_q;
        load_tx  = 1'b0;
        start_rd = 1'b0;
        start_wr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_accept) begin
                    if (is_read_op(rx_data)) begin
                        load_tx = 1'b1;
                        state_n = ST_RESP;
                    end else if (is_write_op(rx_data)) begin
                        state_n = ST_ARG;
                    end
                end
            end
            ST_ARG: begin
                if (rx_accept) begin
                    state_n = ST_IDLE;
                    if (op_q inside {[OP_GPO_WR0:OP_GPO_WR3]}) begin
                        gpo_n = set_byte(gpo, byte_idx(op_q), rx_data);
                    end else if (op_q inside {[OP_ADDR_WR0:OP_ADDR_WR3]}) begin
                        addr_n = set_byte(addr_q, byte_idx(op_q), rx_data);
                    end else if (op_q == OP_AXI_WR) begin
                        start_wr = 1'b1;
                        state_n  = ST_AXI_WR;
                    end else if (op_q == OP_CTRL_WR) begin
                        // The read, if requested, goes to the already-incremented address.
                        if (rx_data[CTRL_WR_INC]) addr_n = addr_q + 32'd1;
                        if (rx_data[CTRL_WR_READ]) begin
                            start_rd = 1'b1;
                            state_n  = ST_AXI_RD;
                        end
                    end
                end
            end
            ST_RESP:   if (tx_done) state_n = ST_IDLE;
            ST_AXI_RD: if (rd_done) state_n = ST_IDLE;
            ST_AXI_WR: if (wr_done) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (m_areset) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            gpo      <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            bresp_q  <= '0;
            tx_data  <= '0;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
        end else begin
            state    <= state_n;
            gpo      <= gpo_n;
            addr_q   <= addr_n;
            rx_ready <= (state_n == ST_IDLE) || (state_n == ST_ARG);
            tx_valid <= (state_n == ST_RESP);
            if (rx_accept && state == ST_IDLE) op_q <= rx_data;
            if (load_tx) tx_data <= resp_byte;
            if (rd_done) begin
                rdata_q <= m_axi_rdata;
                rresp_q <= m_axi_rresp;
            end
            if (wr_done) bresp_q <= m_axi_bresp;
        end
    end

    uart_probe_axi_master u_axi (
        .clk           (clk),
        .m_areset      (m_areset),
        .start_rd      (start_rd),
        .start_wr      (start_wr),
        .rd_addr       (addr_n),
        .wr_addr       (addr_q),
        .wr_data       ({24'h0, rx_data}),
        .rd_done       (rd_done),
        .wr_done       (wr_done),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

endmodule

// File: tb/tb_uart_probe.sv
// Self-checking bench for uart_probe: table-driven command/response vectors plus
// hand-written AXI write, AXI read, address-wrap and mid-transaction reset sequences.
module tb_uart_probe;

    logic        clk = 1'b0;
    logic        m_areset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] gpo;
    logic [31:0] gpi;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arsize;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awsize;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_probe dut (
        .clk           (clk),
        .m_areset      (m_areset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .gpo           (gpo),
        .gpi           (gpi),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    typedef struct {
        logic [7:0]  op;
        bit          has_arg;
        logic [7:0]  arg;
        bit          has_resp;
        logic [7:0]  resp;
        logic [31:0] gpi;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] op, input bit has_arg, input logic [7:0] arg,
                                input bit has_resp, input logic [7:0] resp, input logic [31:0] g);
        vec_t v;
        v.op = op; v.has_arg = has_arg; v.arg = arg;
        v.has_resp = has_resp; v.resp = resp; v.gpi = g;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Returns #1 after the clock edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            timeout_fail($sformatf("rx_accept_%02h", b));
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Returns #1 after the clock edge that transferred the byte.
    task automatic recv_byte(input string name, input logic [7:0] exp);
        int n;
        @(negedge clk);
        n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            timeout_fail({name, "_tx_valid"});
            return;
        end
        check(name, {24'h0, tx_data}, {24'h0, exp});
        tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
    endtask

    task automatic wait_bready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!m_axi_bready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout_fail(name);
    endtask

    // Opcode 17 with a W-before-AW handshake order, then a B response.
    task automatic do_axi_write(input logic [31:0] exp_addr, input logic [7:0] operand,
                                input logic [1:0] bresp);
        send_byte(8'h17);
        send_byte(operand);
        check("wr_aw_w_valid_together", {30'h0, m_axi_awvalid, m_axi_wvalid}, 32'h3);
        check("wr_awaddr", m_axi_awaddr, exp_addr);
        check("wr_wdata", m_axi_wdata, {24'h0, operand});
        check("wr_wstrb_awsize", {25'h0, m_axi_wstrb, m_axi_awsize}, {25'h0, 4'hF, 3'b010});
        check("wr_rx_ready_low", {31'h0, rx_ready}, 32'h0);
        @(negedge clk) m_axi_wready = 1'b1;
        @(posedge clk);
        #1 m_axi_wready = 1'b0;
        check("wr_w_only_done", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h4);
        @(negedge clk) m_axi_awready = 1'b1;
        @(posedge clk);
        #1 m_axi_awready = 1'b0;
        check("wr_aw_dropped", {31'h0, m_axi_awvalid}, 32'h0);
        wait_bready("wr_bready");
        check("wr_rx_ready_low_before_b", {31'h0, rx_ready}, 32'h0);
        m_axi_bresp  = bresp;
        m_axi_bvalid = 1'b1;
        @(posedge clk);
        #1 m_axi_bvalid = 1'b0;
        check("wr_after_b", {30'h0, m_axi_bready, rx_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m_areset = 1'b1;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; gpi = 32'h0;
        m_axi_arready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
        m_axi_rdata = 32'h0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_handshake_outs", {26'h0, rx_ready, tx_valid, m_axi_arvalid, m_axi_awvalid,
                                     m_axi_wvalid, m_axi_bready | m_axi_rready}, 32'h0);
        check("rst_gpo", gpo, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_axi_regs", m_axi_awaddr | m_axi_araddr | m_axi_wdata, 32'h0);
        m_areset = 1'b0;
        @(posedge clk);
        #1 check("rst_rx_ready_after_release", {31'h0, rx_ready}, 32'h1);

        // Directed command table
        vecs.push_back(mk(8'h12, 1, 8'h00, 0, 8'h00, 32'h12345678));
        vecs.push_back(mk(8'h13, 1, 8'h02, 0, 8'h00, 32'h12345678));
        vecs.push_back(mk(8'h14, 1, 8'hC0, 0, 8'h00, 32'h12345678));
        vecs.push_back(mk(8'h15, 1, 8'hBF, 0, 8'h00, 32'h12345678));
        vecs.push_back(mk(8'h0E, 0, 8'h00, 1, 8'h00, 32'h12345678));
        vecs.push_back(mk(8'h0F, 0, 8'h00, 1, 8'h02, 32'h12345678));
        vecs.push_back(mk(8'h10, 0, 8'h00, 1, 8'hC0, 32'h12345678));
        vecs.push_back(mk(8'h11, 0, 8'h00, 1, 8'hBF, 32'h12345678));
        vecs.push_back(mk(8'h04, 0, 8'h00, 1, 8'h34, 32'h12345678));
        vecs.push_back(mk(8'h02, 0, 8'h00, 1, 8'h78, 32'h12345678));
        vecs.push_back(mk(8'h03, 0, 8'h00, 1, 8'h56, 32'h12345678));
        vecs.push_back(mk(8'h05, 0, 8'h00, 1, 8'h12, 32'h12345678));
        vecs.push_back(mk(8'h02, 0, 8'h00, 1, 8'h0D, 32'hCAFEF00D));
        vecs.push_back(mk(8'h0B, 1, 8'hA5, 0, 8'h00, 32'h0));
        vecs.push_back(mk(8'h07, 0, 8'h00, 1, 8'hA5, 32'h0));
        vecs.push_back(mk(8'h06, 0, 8'h00, 1, 8'h00, 32'h0));
        vecs.push_back(mk(8'h08, 0, 8'h00, 1, 8'h00, 32'h0));
        vecs.push_back(mk(8'h09, 0, 8'h00, 1, 8'h00, 32'h0));
        vecs.push_back(mk(8'h0A, 1, 8'h3C, 0, 8'h00, 32'h0));
        vecs.push_back(mk(8'h06, 0, 8'h00, 1, 8'h3C, 32'h0));
        vecs.push_back(mk(8'h07, 0, 8'h00, 1, 8'hA5, 32'h0));
        vecs.push_back(mk(8'h00, 0, 8'h00, 0, 8'h00, 32'h0));
        vecs.push_back(mk(8'h01, 0, 8'h00, 0, 8'h00, 32'h0));
        vecs.push_back(mk(8'h1A, 0, 8'h00, 0, 8'h00, 32'h0));
        vecs.push_back(mk(8'hFF, 0, 8'h00, 0, 8'h00, 32'h0));
        vecs.push_back(mk(8'h07, 0, 8'h00, 1, 8'hA5, 32'h0));
        vecs.push_back(mk(8'h18, 0, 8'h00, 1, 8'h00, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            gpi = vecs[i].gpi;
            send_byte(vecs[i].op);
            if (vecs[i].has_arg) send_byte(vecs[i].arg);
            if (vecs[i].has_resp) begin
                recv_byte($sformatf("vec%0d_op%02h", i, vecs[i].op), vecs[i].resp);
            end else begin
                repeat (3) @(negedge clk);
                check($sformatf("vec%0d_op%02h_no_resp", i, vecs[i].op),
                      {30'h0, tx_valid, rx_ready}, 32'h1);
            end
        end
        check("gpo_after_table", gpo, 32'h0000A53C);

        // AXI write at BFC00200
        do_axi_write(32'hBFC00200, 8'h5A, 2'b00);

        // Ctrl write 03: increment then read at BFC00201
        send_byte(8'h19);
        send_byte(8'h03);
        check("rd_arvalid", {31'h0, m_axi_arvalid}, 32'h1);
        check("rd_araddr", m_axi_araddr, 32'hBFC00201);
        check("rd_arsize", {29'h0, m_axi_arsize}, 32'h2);
        check("rd_rx_ready_low", {31'h0, rx_ready}, 32'h0);
        repeat (2) @(posedge clk);
        #1 check("rd_arvalid_held", {30'h0, m_axi_arvalid, m_axi_rready}, 32'h2);
        @(negedge clk) m_axi_arready = 1'b1;
        @(posedge clk);
        #1 m_axi_arready = 1'b0;
        check("rd_after_ar", {30'h0, m_axi_arvalid, m_axi_rready}, 32'h1);
        repeat (2) @(posedge clk);
        #1 check("rd_rready_held", {30'h0, m_axi_rready, rx_ready}, 32'h2);
        @(negedge clk);
        m_axi_rdata  = 32'hDEADBEEF;
        m_axi_rresp  = 2'b10;
        m_axi_rvalid = 1'b1;
        @(posedge clk);
        #1 m_axi_rvalid = 1'b0;
        check("rd_after_r", {30'h0, m_axi_rready, rx_ready}, 32'h1);

        // Opcode 16 with response held off by tx_ready
        send_byte(8'h16);
        check("resp_latency", {31'h0, tx_valid}, 32'h1);
        repeat (2) @(posedge clk);
        #1 check("resp_stable", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hEF});
        recv_byte("data_rd", 8'hEF);
        check("resp_dropped", {30'h0, tx_valid, rx_ready}, 32'h1);
        send_byte(8'h18);
        recv_byte("ctrl_rd_rresp", 8'h20);
        send_byte(8'h0E);
        recv_byte("addr_incremented", 8'h01);

        // Second write with a nonzero bresp, then ctrl reflects both responses
        do_axi_write(32'hBFC00201, 8'h81, 2'b11);
        send_byte(8'h18);
        recv_byte("ctrl_rd_both", 8'h2C);

        // Address wrap without a read
        send_byte(8'h12); send_byte(8'hFF);
        send_byte(8'h13); send_byte(8'hFF);
        send_byte(8'h14); send_byte(8'hFF);
        send_byte(8'h15); send_byte(8'hFF);
        send_byte(8'h19);
        send_byte(8'h02);
        check("wrap_no_read", {30'h0, m_axi_arvalid, rx_ready}, 32'h1);
        send_byte(8'h0E);
        recv_byte("wrap_byte0", 8'h00);
        send_byte(8'h11);
        recv_byte("wrap_byte3", 8'h00);

        // Reset while a read address is pending
        send_byte(8'h12); send_byte(8'h40);
        send_byte(8'h19);
        send_byte(8'h01);
        check("abort_arvalid_before", {31'h0, m_axi_arvalid}, 32'h1);
        @(negedge clk) m_areset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) m_areset = 1'b0;
        @(posedge clk);
        #1 check("abort_after_release", {30'h0, m_axi_arvalid, rx_ready}, 32'h1);
        check("abort_gpo", gpo, 32'h0);
        @(negedge clk) m_axi_arready = 1'b1;
        repeat (2) @(posedge clk);
        #1 m_axi_arready = 1'b0;
        check("abort_no_resume", {29'h0, m_axi_arvalid, m_axi_rready, rx_ready}, 32'h1);
        send_byte(8'h06);
        recv_byte("abort_gpo_rd", 8'h00);
        send_byte(8'h0E);
        recv_byte("abort_addr_rd", 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
